// File: rtl/sev_seg_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller.
// Holds the conversion FSM state encoding, the digit codes understood by the
// character decoder, and the double-dabble nibble adjust helper.
package sev_seg_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Digit codes: 0..9 are numerals, everything else is a symbol.
    localparam logic [3:0] CODE_ZERO  = 4'h0;
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Number of binary bits shifted through the BCD converter.
    localparam int CONV_BITS = 8;

    // Double-dabble correction: a nibble of 5 or more would carry past 9
    // after the next doubling, so pre-add 3 to land on the right BCD digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/sev_seg_char_decoder.sv
// Purpose: maps a 4-bit digit code to active-high segments {dp, g..a}.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: code (digit code in), seg (segment pattern out; dp always 0).
module sev_seg_char_decoder
    import sev_seg_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'h00;
        case (code)
            4'h0:       seg = 8'h3F;
            4'h1:       seg = 8'h06;
            4'h2:       seg = 8'h5B;
            4'h3:       seg = 8'h4F;
            4'h4:       seg = 8'h66;
            4'h5:       seg = 8'h6D;
            4'h6:       seg = 8'h7D;
            4'h7:       seg = 8'h07;
            4'h8:       seg = 8'h7F;
            4'h9:       seg = 8'h6F;
            CODE_MINUS: seg = 8'h40;
            default:    seg = 8'h00;   // CODE_BLANK and unused codes
        endcase
    end

endmodule

// File: rtl/sev_seg_ctrl.sv
// Purpose: converts a byte (signed or unsigned) to decimal and scans it onto a 4-digit display.
// Latency: display updates 8 cycles after the load edge; segs/sel are registered, one cycle behind the scan state.
// Backpressure: busy is high during conversion; load pulses while busy are dropped.
// Ports: clk, rst (async, active-high), value/load/twos_complement (operand capture),
//        busy (conversion running), segs ({dp, g..a}), sel (one-hot digit select, sel[0] rightmost).
module sev_seg_ctrl
    import sev_seg_ctrl_pkg::*;
#(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_HIGH  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       twos_complement,
    output logic       busy,
    output logic [7:0] segs,
    output logic [3:0] sel
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [7:0]      SEGS_OFF   = ACTIVE_HIGH ? 8'h00 : 8'hFF;
    localparam logic [3:0]      SEL_OFF    = ACTIVE_HIGH ? 4'h0  : 4'hF;

    // ---------------------------------------------------------------
    // Conversion FSM
    // ---------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [2:0]  bit_cnt;
    logic        last_bit;

    assign last_bit = (bit_cnt == 3'(CONV_BITS - 1));
    assign busy     = (state == CONV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load)     state_nxt = CONV;
            CONV:    if (last_bit) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Operand capture and double-dabble datapath
    // ---------------------------------------------------------------
    logic        neg_in;
    logic [7:0]  mag;
    logic [7:0]  shreg;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_nxt;
    logic        neg_pend;

    // 256-value kept to 8 bits: the largest magnitude is 128 (0x80), so the
    // truncated two's-complement negate is exact.
    assign neg_in  = twos_complement & value[7];
    assign mag     = neg_in ? (~value + 8'd1) : value;

    assign bcd_adj = {dd_adjust(bcd[11:8]), dd_adjust(bcd[7:4]), dd_adjust(bcd[3:0])};
    assign bcd_nxt = {bcd_adj[10:0], shreg[7]};

    // Display registers: committed only when the last bit has been shifted,
    // so an aborted conversion never leaks a partial result.
    logic        neg;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            bcd      <= '0;
            neg_pend <= 1'b0;
            neg      <= 1'b0;
            d0       <= CODE_ZERO;
            d1       <= CODE_BLANK;
            d2       <= CODE_BLANK;
        end else if (state == IDLE) begin
            if (load) begin
                shreg    <= mag;
                neg_pend <= neg_in;
                bcd      <= '0;
                bit_cnt  <= '0;
            end
        end else begin
            shreg   <= {shreg[6:0], 1'b0};
            bcd     <= bcd_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
                neg <= neg_pend;
                d0  <= bcd_nxt[3:0];
                d1  <= ((bcd_nxt[11:8] == 4'd0) && (bcd_nxt[7:4] == 4'd0)) ? CODE_BLANK
                                                                           : bcd_nxt[7:4];
                d2  <= (bcd_nxt[11:8] == 4'd0) ? CODE_BLANK : bcd_nxt[11:8];
            end
        end
    end

    // ---------------------------------------------------------------
    // Scanning: free-running, independent of the converter
    // ---------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [1:0]    idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    logic [3:0] cur_code;
    logic [7:0] cur_seg;
    logic [3:0] cur_sel;
    logic       blanking;

    always_comb begin
        cur_code = d0;
        case (idx)
            2'd0:    cur_code = d0;
            2'd1:    cur_code = d1;
            2'd2:    cur_code = d2;
            default: cur_code = neg ? CODE_MINUS : CODE_BLANK;
        endcase
    end

    sev_seg_char_decoder u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

    assign cur_sel  = 4'b0001 << idx;
    // Opening cycles of each slot are dark so the previous digit's charge
    // does not ghost onto the newly selected one.
    assign blanking = (presc < BLANK_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segs <= SEGS_OFF;
            sel  <= SEL_OFF;
        end else if (blanking) begin
            segs <= SEGS_OFF;
            sel  <= SEL_OFF;
        end else begin
            segs <= ACTIVE_HIGH ? cur_seg : ~cur_seg;
            sel  <= ACTIVE_HIGH ? cur_sel : ~cur_sel;
        end
    end

endmodule

// File: tb/tb_sev_seg_ctrl.sv
// Self-checking bench for sev_seg_ctrl with PRESCALE=4, BLANK_CYCLES=1, ACTIVE_HIGH=0.
// A behavioural model (decimal arithmetic and cycle counting) predicts busy/sel/segs every cycle;
// a vector table plus hand sequences check specific display contents.
module tb_sev_seg_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       load;
    logic       twos_complement;
    logic       busy;
    logic [7:0] segs;
    logic [3:0] sel;

    sev_seg_ctrl #(
        .PRESCALE     (4),
        .BLANK_CYCLES (1),
        .ACTIVE_HIGH  (1'b0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .value           (value),
        .load            (load),
        .twos_complement (twos_complement),
        .busy            (busy),
        .segs            (segs),
        .sel             (sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // Active-low segment bytes for numerals 0..9.
    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int         cyc    = 0;     // clock edges since reset release
    bit         m_busy = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] p_val  = 8'h00;
    logic       p_tc   = 1'b0;
    logic [7:0] m_disp [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};  // index = digit position
    logic [7:0] m_prev [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};  // display as seen by the output register

    task automatic model_commit(input logic [7:0] v, input logic tc);
        bit neg;
        int mag;
        neg = tc && v[7];
        mag = neg ? 256 - int'(v) : int'(v);
        m_disp[3] = neg ? 8'hBF : 8'hFF;
        m_disp[2] = (mag >= 100) ? seg_lut[mag / 100] : 8'hFF;
        m_disp[1] = (mag >= 10)  ? seg_lut[(mag / 10) % 10] : 8'hFF;
        m_disp[0] = seg_lut[mag % 10];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc    = 0;
            m_busy = 1'b0;
            m_cnt  = 0;
            m_disp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
            m_prev = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        end else begin
            cyc++;
            m_prev = m_disp;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 8) begin
                    model_commit(p_val, p_tc);
                    m_busy = 1'b0;
                end
            end else if (load) begin
                p_val  = value;
                p_tc   = twos_complement;
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    task automatic check_outputs();
        logic [3:0] es;
        logic [7:0] eg;
        int p, slot;
        es = 4'hF;
        eg = 8'hFF;
        if (!rst && cyc > 0) begin
            p    = (cyc - 1) % 16;
            slot = p / 4;
            if ((p % 4) != 0) begin
                es = ~(4'b0001 << slot);
                eg = m_prev[slot];
            end
        end
        chk("busy", {7'b0, busy}, {7'b0, m_busy});
        chk("sel",  {4'b0, sel},  {4'b0, es});
        chk("segs", segs, eg);
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_idle_timeout"}, {7'b0, busy}, 8'h00);
    endtask

    logic [7:0] cap [4];

    task automatic capture();
        for (int k = 0; k < 4; k++) cap[k] = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            case (sel)
                4'b1110: cap[0] = segs;
                4'b1101: cap[1] = segs;
                4'b1011: cap[2] = segs;
                4'b0111: cap[3] = segs;
                default: ;
            endcase
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]  value;
        logic        tc;
        logic [31:0] exp;   // {d3, d2, d1, d0} active-low segments
    } vec_t;

    vec_t vecs [12];

    initial begin
        int         n;
        logic [31:0] e;

        vecs[0]  = '{8'd255, 1'b0, 32'hFF_A4_92_92};  // 255
        vecs[1]  = '{8'h80,  1'b1, 32'hBF_F9_A4_80};  // -128
        vecs[2]  = '{8'hFF,  1'b1, 32'hBF_FF_FF_F9};  // -1
        vecs[3]  = '{8'd0,   1'b0, 32'hFF_FF_FF_C0};  // 0
        vecs[4]  = '{8'd100, 1'b0, 32'hFF_F9_C0_C0};  // 100 (inner zero shown)
        vecs[5]  = '{8'h9C,  1'b1, 32'hBF_F9_C0_C0};  // -100
        vecs[6]  = '{8'hF6,  1'b1, 32'hBF_FF_F9_C0};  // -10
        vecs[7]  = '{8'd99,  1'b0, 32'hFF_FF_90_90};  // 99
        vecs[8]  = '{8'd127, 1'b1, 32'hFF_F9_A4_F8};  // 127 signed positive
        vecs[9]  = '{8'h80,  1'b0, 32'hFF_F9_A4_80};  // 128 unsigned
        vecs[10] = '{8'd42,  1'b1, 32'hFF_FF_99_A4};  // 42
        vecs[11] = '{8'hC8,  1'b1, 32'hBF_FF_92_82};  // -56

        rst             = 1'b1;
        load            = 1'b0;
        value           = 8'h00;
        twos_complement = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("rst_sel",  {4'b0, sel},  8'h0F);
        chk("rst_segs", segs,         8'hFF);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        rst = 1'b0;

        // Display after reset: "   0"
        capture();
        chk("post_rst_d0", cap[0], 8'hC0);
        chk("post_rst_d1", cap[1], 8'hFF);
        chk("post_rst_d2", cap[2], 8'hFF);
        chk("post_rst_d3", cap[3], 8'hFF);

        // Table-driven conversions
        for (int i = 0; i < 12; i++) begin
            wait_idle($sformatf("v%0d_pre", i), n);
            value           = vecs[i].value;
            twos_complement = vecs[i].tc;
            load            = 1'b1;
            step();
            load = 1'b0;
            chk($sformatf("v%0d_busy_rise", i), {7'b0, busy}, 8'h01);
            wait_idle($sformatf("v%0d", i), n);
            chk($sformatf("v%0d_busy_len", i), 8'(n), 8'd8);
            capture();
            e = vecs[i].exp;
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_d%0d", i, k), cap[k], e[8*k +: 8]);
        end

        // Load while busy is ignored
        wait_idle("ign_pre", n);
        twos_complement = 1'b0;
        value = 8'd7;
        load  = 1'b1;
        step();
        value = 8'd9;
        step();
        load = 1'b0;
        wait_idle("ign", n);
        capture();
        chk("ign_d0", cap[0], 8'hF8);
        chk("ign_d1", cap[1], 8'hFF);
        chk("ign_d3", cap[3], 8'hFF);

        // Reset during the 4th conversion cycle aborts it
        wait_idle("abort_pre", n);
        value = 8'd99;
        load  = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort_busy", {7'b0, busy}, 8'h00);
        chk("abort_sel",  {4'b0, sel},  8'h0F);
        chk("abort_segs", segs,         8'hFF);
        step();
        step();
        rst = 1'b0;
        capture();
        chk("abort_d0", cap[0], 8'hC0);
        chk("abort_d1", cap[1], 8'hFF);
        chk("abort_d2", cap[2], 8'hFF);
        chk("abort_d3", cap[3], 8'hFF);

        // Random loads (many while busy, commits landing mid-slot)
        for (int r = 0; r < 400; r++) begin
            value           = 8'($urandom);
            twos_complement = 1'($urandom_range(0, 1));
            load            = ($urandom_range(0, 2) == 0);
            step();
        end
        load = 1'b0;
        for (int r = 0; r < 20; r++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
